si5340_page_sequencer: RTL and testbench
========================================

SI5340_PAGE_SEQUENCER -- requirements
Module: si5340_page_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h74, the 7-bit I2C device address driven on every request.
REQ-002 SHALL have parameter PAUSE_CYCLES, default 16, the clk_i cycles waited after a pause-flagged entry (must be >= 1).
REQ-003 SHALL have parameter RETRIES, default 2, the extra attempts allowed per I2C write after a NACK.
REQ-004 SHALL have the following ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  pulse that begins a configuration sequence.
- cfg_valid_i  in  1  config entry valid.
- cfg_ready_o  out  1  entry accepted on valid&&ready.
- cfg_addr_i  in  16  Si5340 register address as {page, reg}.
- cfg_data_i  in  8  register data.
- cfg_pause_i  in  1  wait PAUSE_CYCLES after this entry's write.
- cfg_last_i  in  1  final entry of the sequence.
- i2c_req_o  out  1  write request to the byte-level I2C engine.
- i2c_ack_i  in  1  one-cycle completion strobe from the engine.
- i2c_nack_i  in  1  qualifies i2c_ack_i: the transfer was NACKed.
- i2c_dev_o  out  7  device address.
- i2c_reg_o  out  8  register byte.
- i2c_data_o  out  8  data byte.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse when the sequence completes.
- err_o  out  1  sticky failure flag.

Function
REQ-005 SHALL implement the states IDLE, FETCH, PAGE_REQ, REG_REQ, PAUSE, DONE and FAIL.
REQ-006 SHALL, in IDLE on start_i, clear err_o, invalidate the page cache and go to FETCH in the next cycle.
REQ-007 SHALL ignore start_i in every state other than IDLE.
REQ-008 SHALL assert cfg_ready_o only in FETCH, and SHALL latch addr, data, pause and last on valid&&ready.
REQ-009 SHALL, after accepting an entry, go to REG_REQ when the cache is valid and equal to addr[15:8]; otherwise it SHALL go to PAGE_REQ.
REQ-010 SHALL, in PAGE_REQ, drive reg=8'h01 and data=addr[15:8].
REQ-011 SHALL, on a clean ack in PAGE_REQ, set cache=addr[15:8], mark the cache valid and go to REG_REQ.
REQ-012 SHALL, in REG_REQ, drive reg=addr[7:0] and data=latched data.
REQ-013 SHALL, on a clean ack in REG_REQ, go to PAUSE if pause is set, else to DONE if last is set, else to FETCH.
REQ-014 SHALL, when a REG_REQ entry targets reg 8'h01, load the cache with its data byte on a clean ack.
REQ-015 SHALL hold i2c_req_o high from the cycle the state is entered until the cycle i2c_ack_i is sampled, and SHALL drive it low in the following cycle.
REQ-016 SHALL keep i2c_dev_o, i2c_reg_o and i2c_data_o stable while i2c_req_o is high.
REQ-017 SHALL, on ack with nack, increment a per-write retry counter and re-assert the request after one idle cycle, with the counter cleared on each new write.
REQ-018 SHALL, on a nack when the counter equals RETRIES, set err_o and go to FAIL.
REQ-019 SHALL, in PAUSE, count PAUSE_CYCLES cycles and then go to DONE if last is set, else to FETCH.
REQ-020 SHALL, in DONE, pulse done_o for exactly one cycle and return to IDLE.
REQ-021 SHALL, in FAIL, return to IDLE in the next cycle without asserting done_o.
REQ-022 SHALL hold err_o set until the next accepted start_i.
REQ-023 SHALL drive busy_o high in every state except IDLE.
REQ-024 SHALL ignore an ack arriving while i2c_req_o is low.

Reset
REQ-025 SHALL, while rst_i is high at a clk_i edge, force state=IDLE and drive cfg_ready_o=0, i2c_req_o=0, i2c_dev_o=DEV_ADDR, i2c_reg_o=0, i2c_data_o=0, busy_o=0, done_o=0 and err_o=0.
REQ-026 SHALL, at reset, clear the page cache, retry counter and pause counter.
REQ-027 SHALL, on reset mid-transfer, drop i2c_req_o in the cycle after rst_i is sampled.

Verification
REQ-028 Bench SHALL cover entries 0x0B24/0xC0, then 0x0B25/0x00 (last) with immediate acks -> writes (01,0B), (24,C0), (25,00); exactly one page write; done_o pulses once.
REQ-029 Bench SHALL cover entries 0x0B24 then 0x0C10 -> writes (01,0B), (24,xx), (01,0C), (10,xx).
REQ-030 Bench SHALL cover entry 0x0001/0x05 followed by 0x0540 -> write (01,00), then (01,05), then (40,xx) with no further page write.
REQ-031 Bench SHALL cover a pause-flagged entry with PAUSE_CYCLES=16 -> cfg_ready_o stays low for 16 cycles after the ack before the next entry is accepted.
REQ-032 Bench SHALL cover a NACK on every attempt with RETRIES=2 -> 3 requests issued, err_o=1, done_o never pulses, IDLE reached, and the next start_i clears err_o.
REQ-033 Bench SHALL cover rst_i asserted while i2c_req_o is high -> i2c_req_o=0 in the next cycle, and a following start_i re-issues the page write because the cache is invalid.

Source files
------------

// File: rtl/si5340_page_sequencer.sv
// Streams {page,reg}/data entries to a byte-level I2C write engine for an Si5340,
// inserting page-select writes only when the target page differs from the cached one.
//
// state    | meaning
// IDLE     | waiting for start_i
// FETCH    | accepting the next config entry
// PAGE_REQ | writing the page register (0x01)
// REG_REQ  | writing the target register
// PAUSE    | settle delay after a pause-flagged entry
// DONE     | one-cycle completion pulse
// FAIL     | retries exhausted, back to IDLE
module si5340_page_sequencer #(
    parameter logic [6:0] DEV_ADDR     = 7'h74,
    parameter int         PAUSE_CYCLES = 16,
    parameter int         RETRIES      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [15:0] cfg_addr_i,
    input  logic [7:0]  cfg_data_i,
    input  logic        cfg_pause_i,
    input  logic        cfg_last_i,
    output logic        i2c_req_o,
    input  logic        i2c_ack_i,
    input  logic        i2c_nack_i,
    output logic [6:0]  i2c_dev_o,
    output logic [7:0]  i2c_reg_o,
    output logic [7:0]  i2c_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    localparam int PW = $clog2(PAUSE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_PAGE_REQ, ST_REG_REQ, ST_PAUSE, ST_DONE, ST_FAIL
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic           pause_q, pause_d;
    logic           last_q, last_d;
    logic [7:0]     cache_q, cache_d;
    logic           cache_vld_q, cache_vld_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           gap_q, gap_d;
    logic           err_q, err_d;
    logic           ack_v, ack_ok, ack_bad;

    // gap_q forces one low request cycle after every sampled ack
    assign i2c_req_o   = ((state_q == ST_PAGE_REQ) || (state_q == ST_REG_REQ)) && !gap_q;
    assign ack_v       = i2c_ack_i && i2c_req_o;
    assign ack_ok      = ack_v && !i2c_nack_i;
    assign ack_bad     = ack_v && i2c_nack_i;
    assign cfg_ready_o = (state_q == ST_FETCH);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;
    assign i2c_dev_o   = DEV_ADDR;

    always_comb begin
        i2c_reg_o  = 8'h00;
        i2c_data_o = 8'h00;
        if (state_q == ST_PAGE_REQ) begin
            i2c_reg_o  = 8'h01;
            i2c_data_o = addr_q[15:8];
        end else if (state_q == ST_REG_REQ) begin
            i2c_reg_o  = addr_q[7:0];
            i2c_data_o = data_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pause_d     = pause_q;
        last_d      = last_q;
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        retry_d     = retry_q;
        pcnt_d      = pcnt_q;
        gap_d       = ack_v;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d       = 1'b0;
                    cache_vld_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                retry_d = '0;
                if (cfg_valid_i) begin
                    addr_d  = cfg_addr_i;
                    data_d  = cfg_data_i;
                    pause_d = cfg_pause_i;
                    last_d  = cfg_last_i;
                    state_d = (cache_vld_q && (cache_q == cfg_addr_i[15:8])) ? ST_REG_REQ
                                                                             : ST_PAGE_REQ;
                end
            end
            ST_PAGE_REQ, ST_REG_REQ: begin
                if (ack_ok) begin
                    retry_d = '0;
                    if (state_q == ST_PAGE_REQ) begin
                        cache_d     = addr_q[15:8];
                        cache_vld_d = 1'b1;
                        state_d     = ST_REG_REQ;
                    end else begin
                        // a direct write to the page register also moves the device page
                        if (addr_q[7:0] == 8'h01) begin
                            cache_d     = data_q;
                            cache_vld_d = 1'b1;
                        end
                        if (pause_q) begin
                            pcnt_d  = PW'(PAUSE_CYCLES - 1);
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = last_q ? ST_DONE : ST_FETCH;
                        end
                    end
                end else if (ack_bad) begin
                    if (retry_q == RW'(RETRIES)) begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + RW'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (pcnt_q == '0) begin
                    state_d = last_q ? ST_DONE : ST_FETCH;
                end else begin
                    pcnt_d = pcnt_q - PW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            pause_q     <= 1'b0;
            last_q      <= 1'b0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            retry_q     <= '0;
            pcnt_q      <= '0;
            gap_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pause_q     <= pause_d;
            last_q      <= last_d;
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            retry_q     <= retry_d;
            pcnt_q      <= pcnt_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_si5340_page_sequencer.sv
// Bench for si5340_page_sequencer: a modelled I2C engine answers requests while a
// scoreboard compares each issued write against the queued expected writes.
module tb_si5340_page_sequencer;
    logic        clk = 1'b0;
    logic        rst_i, start_i, cfg_valid_i, cfg_ready_o, cfg_pause_i, cfg_last_i;
    logic [15:0] cfg_addr_i;
    logic [7:0]  cfg_data_i;
    logic        i2c_req_o, i2c_ack_i, i2c_nack_i, busy_o, done_o, err_o;
    logic [6:0]  i2c_dev_o;
    logic [7:0]  i2c_reg_o, i2c_data_o;

    always #5 clk = ~clk;

    si5340_page_sequencer #(.DEV_ADDR(7'h74), .PAUSE_CYCLES(16), .RETRIES(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .cfg_pause_i(cfg_pause_i), .cfg_last_i(cfg_last_i),
        .i2c_req_o(i2c_req_o), .i2c_ack_i(i2c_ack_i), .i2c_nack_i(i2c_nack_i),
        .i2c_dev_o(i2c_dev_o), .i2c_reg_o(i2c_reg_o), .i2c_data_o(i2c_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    int          req_cnt = 0, page_cnt = 0, done_cnt = 0;
    int          ack_dly = 0;
    bit          nack_mode = 1'b0, stray = 1'b0, hold_ack = 1'b0;
    logic        req_prev = 1'b0;
    logic [15:0] cur = '0;
    bit          cur_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (i2c_req_o && !req_prev) begin
                req_cnt++;
                if (i2c_reg_o == 8'h01) page_cnt++;
                chk("dev_addr", 32'(i2c_dev_o), 32'h74);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur_vld = 1'b0;
                    $display("FAIL unexpected_write actual=%0h required=none", {i2c_reg_o, i2c_data_o});
                end else begin
                    cur     = exp_q.pop_front();
                    cur_vld = 1'b1;
                    chk("write", 32'({i2c_reg_o, i2c_data_o}), 32'(cur));
                end
            end else if (i2c_req_o && cur_vld) begin
                chk("write_stable", 32'({i2c_reg_o, i2c_data_o}), 32'(cur));
            end
            req_prev = i2c_req_o;
        end
    end

    // I2C engine model
    initial begin
        int hi;
        hi = 0;
        i2c_ack_i  = 1'b0;
        i2c_nack_i = 1'b0;
        forever begin
            @(negedge clk);
            i2c_ack_i  = 1'b0;
            i2c_nack_i = 1'b0;
            if (i2c_req_o) begin
                if (!hold_ack && hi == ack_dly) begin
                    i2c_ack_i  = 1'b1;
                    i2c_nack_i = nack_mode;
                end
                hi++;
            end else begin
                hi = 0;
                if (stray) begin
                    i2c_ack_i  = 1'b1;
                    i2c_nack_i = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic start_pulse();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_entry(input logic [15:0] a, input logic [7:0] d, input logic p, input logic l);
        int n;
        n = 0;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        cfg_pause_i = p;
        cfg_last_i  = l;
        cfg_valid_i = 1'b1;
        while (!cfg_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("entry_accepted", 32'(cfg_ready_o), 32'd1);
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy_o), 32'd0);
    endtask

    task automatic clear_counts();
        req_cnt  = 0;
        page_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        int cnt;
        rst_i = 1'b1; start_i = 1'b0; cfg_valid_i = 1'b0;
        cfg_addr_i = '0; cfg_data_i = '0; cfg_pause_i = 1'b0; cfg_last_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cfg_ready_o), 32'd0);
        chk("rst_req", 32'(i2c_req_o), 32'd0);
        chk("rst_dev", 32'(i2c_dev_o), 32'h74);
        chk("rst_reg_data", 32'({i2c_reg_o, i2c_data_o}), 32'd0);
        chk("rst_busy_done_err", 32'({busy_o, done_o, err_o}), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // two entries on one page: a single page write
        clear_counts();
        exp_q.push_back(16'h010B); exp_q.push_back(16'h24C0); exp_q.push_back(16'h2500);
        start_pulse();
        chk("busy_after_start", 32'(busy_o), 32'd1);
        send_entry(16'h0B24, 8'hC0, 1'b0, 1'b0);
        send_entry(16'h0B25, 8'h00, 1'b0, 1'b1);
        wait_idle();
        chk("t1_req_cnt", 32'(req_cnt), 32'd3);
        chk("t1_page_cnt", 32'(page_cnt), 32'd1);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_err", 32'(err_o), 32'd0);
        chk("t1_queue", 32'(exp_q.size()), 32'd0);

        // page change between entries, engine answers late
        clear_counts();
        ack_dly = 2;
        exp_q.push_back(16'h010B); exp_q.push_back(16'h2411);
        exp_q.push_back(16'h010C); exp_q.push_back(16'h1022);
        start_pulse();
        send_entry(16'h0B24, 8'h11, 1'b0, 1'b0);
        send_entry(16'h0C10, 8'h22, 1'b0, 1'b1);
        wait_idle();
        ack_dly = 0;
        chk("t2_page_cnt", 32'(page_cnt), 32'd2);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_queue", 32'(exp_q.size()), 32'd0);

        // direct page-register write updates the cache; stray acks must be ignored
        clear_counts();
        stray = 1'b1;
        exp_q.push_back(16'h0100); exp_q.push_back(16'h0105); exp_q.push_back(16'h4033);
        start_pulse();
        send_entry(16'h0001, 8'h05, 1'b0, 1'b0);
        send_entry(16'h0540, 8'h33, 1'b0, 1'b1);
        wait_idle();
        stray = 1'b0;
        chk("t3_req_cnt", 32'(req_cnt), 32'd3);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        chk("t3_err", 32'(err_o), 32'd0);
        chk("t3_queue", 32'(exp_q.size()), 32'd0);

        // pause-flagged entry holds off the next fetch for 16 cycles
        clear_counts();
        exp_q.push_back(16'h010B); exp_q.push_back(16'h30AA); exp_q.push_back(16'h31BB);
        start_pulse();
        send_entry(16'h0B30, 8'hAA, 1'b1, 1'b0);
        cnt = 0;
        while (!(i2c_req_o && i2c_reg_o == 8'h30) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        @(negedge clk);
        while (!cfg_ready_o && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("t4_pause_cycles", 32'(cnt), 32'd16);
        send_entry(16'h0B31, 8'hBB, 1'b0, 1'b1);
        wait_idle();
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_queue", 32'(exp_q.size()), 32'd0);

        // persistent NACK: three attempts then FAIL
        clear_counts();
        nack_mode = 1'b1;
        exp_q.push_back(16'h010B); exp_q.push_back(16'h010B); exp_q.push_back(16'h010B);
        start_pulse();
        send_entry(16'h0B24, 8'h01, 1'b0, 1'b1);
        wait_idle();
        nack_mode = 1'b0;
        chk("t5_req_cnt", 32'(req_cnt), 32'd3);
        chk("t5_err", 32'(err_o), 32'd1);
        chk("t5_done_cnt", 32'(done_cnt), 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", 32'(err_o), 32'd1);
        clear_counts();
        exp_q.push_back(16'h010B); exp_q.push_back(16'h2401);
        start_pulse();
        chk("t5_err_cleared", 32'(err_o), 32'd0);
        send_entry(16'h0B24, 8'h01, 1'b0, 1'b1);
        wait_idle();
        chk("t5_recover_done", 32'(done_cnt), 32'd1);
        chk("t5_queue", 32'(exp_q.size()), 32'd0);

        // reset while a request is outstanding
        clear_counts();
        hold_ack = 1'b1;
        exp_q.push_back(16'h010B);
        start_pulse();
        send_entry(16'h0B24, 8'h07, 1'b0, 1'b1);
        chk("t6_req_before_rst", 32'(i2c_req_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_req_after_rst", 32'(i2c_req_o), 32'd0);
        chk("t6_busy_after_rst", 32'(busy_o), 32'd0);
        chk("t6_regdata_after_rst", 32'({i2c_reg_o, i2c_data_o}), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        hold_ack = 1'b0;
        @(negedge clk);
        clear_counts();
        exp_q.push_back(16'h010B); exp_q.push_back(16'h2407);
        start_pulse();
        send_entry(16'h0B24, 8'h07, 1'b0, 1'b1);
        wait_idle();
        chk("t6_page_rewrite", 32'(page_cnt), 32'd1);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
